// File: rtl/imm_decode_pipe_if.sv
// IF/ID-to-ID/EX handshake bundle for the immediate generation pipe.
// master drives instructions and downstream ready; slave is the pipe itself.
interface imm_decode_pipe_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_IN;
  logic        FLUSH;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_IMM;
  logic [2:0]  OUT_SELECT;
  logic [31:0] OUT_PC;
  logic        OUT_ILLEGAL;

  modport master (
    output IN_VALID, INSTRUCTION, PC_IN, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_IMM, OUT_SELECT, OUT_PC, OUT_ILLEGAL
  );

  modport slave (
    input  IN_VALID, INSTRUCTION, PC_IN, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, OUT_IMM, OUT_SELECT, OUT_PC, OUT_ILLEGAL
  );
endinterface

// File: rtl/imm_decode_pipe.sv
// Two-stage valid/ready immediate generator for the ID stage: stage A decodes
// the format select, stage B builds and registers the extended immediate.
module imm_decode_pipe (
  input  logic              CLK,
  input  logic              RESET,
  imm_decode_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    SEL_I    = 3'd0,
    SEL_S    = 3'd1,
    SEL_U    = 3'd2,
    SEL_B    = 3'd3,
    SEL_J    = 3'd4,
    SEL_NONE = 3'd7
  } sel_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic        a_valid;
  logic [31:0] a_instr;
  logic [31:0] a_pc;
  sel_e        a_sel;
  logic        a_illegal;

  logic        out_valid;
  logic [31:0] out_imm;
  sel_e        out_sel;
  logic [31:0] out_pc;
  logic        out_illegal;

  sel_e        dec_sel;
  logic        dec_illegal;
  logic [31:0] imm;
  logic        b_adv;
  logic        a_move;
  logic        in_ready;
  logic        accept;

  assign b_adv    = !out_valid || bus.OUT_READY;
  assign a_move   = a_valid && b_adv;
  assign in_ready = !bus.FLUSH && !RESET && (!a_valid || a_move);
  assign accept   = bus.IN_VALID && in_ready;

  always_comb begin
    dec_sel     = SEL_NONE;
    dec_illegal = 1'b0;
    case (bus.INSTRUCTION[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: dec_sel = SEL_I;
      OP_STORE:                           dec_sel = SEL_S;
      OP_LUI, OP_AUIPC:                   dec_sel = SEL_U;
      OP_BRANCH:                          dec_sel = SEL_B;
      OP_JAL:                             dec_sel = SEL_J;
      OP_REG:                             dec_sel = SEL_NONE;
      default:                            dec_illegal = 1'b1;
    endcase
  end

  // Shift-immediates (funct3 001/101) carry only a 5-bit unsigned shamt.
  always_comb begin
    imm = '0;
    case (a_sel)
      SEL_I: begin
        if (a_instr[6:0] == OP_IMM && a_instr[13:12] == 2'b01)
          imm = {27'b0, a_instr[24:20]};
        else
          imm = {{20{a_instr[31]}}, a_instr[31:20]};
      end
      SEL_S: imm = {{20{a_instr[31]}}, a_instr[31:25], a_instr[11:7]};
      SEL_U: imm = {a_instr[31:12], 12'b0};
      SEL_B: imm = {{19{a_instr[31]}}, a_instr[31], a_instr[7],
                    a_instr[30:25], a_instr[11:8], 1'b0};
      SEL_J: imm = {{11{a_instr[31]}}, a_instr[31], a_instr[19:12],
                    a_instr[20], a_instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_valid     <= 1'b0;
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_sel     <= SEL_NONE;
      out_pc      <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (a_move) begin
        out_imm     <= imm;
        out_sel     <= a_sel;
        out_pc      <= a_pc;
        out_illegal <= a_illegal;
      end
      if (accept) begin
        a_instr   <= bus.INSTRUCTION;
        a_pc      <= bus.PC_IN;
        a_sel     <= dec_sel;
        a_illegal <= dec_illegal;
      end
      // Flush only kills the valid bits; any data loaded above is don't-care.
      if (bus.FLUSH) begin
        a_valid   <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (b_adv)
          out_valid <= a_valid;
        if (accept)
          a_valid <= 1'b1;
        else if (a_move)
          a_valid <= 1'b0;
      end
    end
  end

  assign bus.IN_READY    = in_ready;
  assign bus.OUT_VALID   = out_valid;
  assign bus.OUT_IMM     = out_imm;
  assign bus.OUT_SELECT  = out_sel;
  assign bus.OUT_PC      = out_pc;
  assign bus.OUT_ILLEGAL = out_illegal;

endmodule
